// File: rtl/alarm_led_sequencer.sv
// Alarm LED burst sequencer: flashes PULSES pulses per burst, pauses between bursts,
// and stops in HOLD on acknowledge or after MAX_BURSTS bursts.
module alarm_led_sequencer #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned ON_MS       = 250,
  parameter int unsigned OFF_MS      = 250,
  parameter int unsigned PULSES      = 3,
  parameter int unsigned PAUSE_MS    = 1000,
  parameter int unsigned MAX_BURSTS  = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alarm_in,
  input  logic       ack,
  output logic       led_out,
  output logic       active,
  output logic [7:0] burst_count
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int unsigned PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam int unsigned MAX_OF_2   = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int unsigned MAX_MS     = (MAX_OF_2 > PAUSE_MS) ? MAX_OF_2 : PAUSE_MS;
  localparam int unsigned MS_W       = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;
  localparam int unsigned PULSE_W    = $clog2(PULSES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ON    = 3'd1,
    S_OFF   = 3'd2,
    S_PAUSE = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e             state_q;
  logic               sync1_q, sync2_q;
  logic [PRE_W-1:0]   pre_q;
  logic [MS_W-1:0]    ms_q;
  logic [PULSE_W-1:0] pulse_q;
  logic [7:0]         burst_q;
  logic [7:0]         burst_d;
  logic               led_q, active_q;

  logic [MS_W-1:0]    phase_last_c;
  logic               ms_tick_c;
  logic               phase_done_c;
  logic               limit_hit_c;

  // Phase timer decode and saturating burst increment
  always_comb begin
    phase_last_c = MS_W'(ON_MS - 1);
    case (state_q)
      S_OFF:   phase_last_c = MS_W'(OFF_MS - 1);
      S_PAUSE: phase_last_c = MS_W'(PAUSE_MS - 1);
      default: phase_last_c = MS_W'(ON_MS - 1);
    endcase
    ms_tick_c    = (pre_q == PRE_W'(CYC_PER_MS - 1));
    phase_done_c = ms_tick_c && (ms_q == phase_last_c);
    burst_d      = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
    limit_hit_c  = (MAX_BURSTS != 0) && (burst_d == 8'(MAX_BURSTS));
  end

  // Synchroniser, FSM, timers and registered outputs; timers clear on every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      pre_q    <= '0;
      ms_q     <= '0;
      pulse_q  <= '0;
      burst_q  <= '0;
      led_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sync1_q <= alarm_in;
      sync2_q <= sync1_q;
      pre_q   <= '0;
      ms_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (sync2_q) begin
            state_q  <= S_ON;
            pulse_q  <= '0;
            burst_q  <= '0;
            led_q    <= 1'b1;
            active_q <= 1'b1;
          end
        end
        S_ON, S_OFF, S_PAUSE: begin
          if (!sync2_q) begin
            state_q  <= S_IDLE;
            led_q    <= 1'b0;
            active_q <= 1'b0;
          end else if (ack) begin
            state_q  <= S_HOLD;
            led_q    <= 1'b0;
            active_q <= 1'b0;
          end else if (phase_done_c) begin
            case (state_q)
              S_ON: begin
                state_q <= S_OFF;
                led_q   <= 1'b0;
                pulse_q <= pulse_q + PULSE_W'(1);
              end
              S_OFF: begin
                if (pulse_q < PULSE_W'(PULSES)) begin
                  state_q <= S_ON;
                  led_q   <= 1'b1;
                end else begin
                  burst_q <= burst_d;
                  pulse_q <= '0;
                  if (limit_hit_c) begin
                    state_q  <= S_HOLD;
                    active_q <= 1'b0;
                  end else begin
                    state_q <= S_PAUSE;
                  end
                end
              end
              default: begin
                state_q <= S_ON;
                led_q   <= 1'b1;
              end
            endcase
          end else if (ms_tick_c) begin
            ms_q <= ms_q + MS_W'(1);
          end else begin
            pre_q <= pre_q + PRE_W'(1);
            ms_q  <= ms_q;
          end
        end
        S_HOLD: begin
          if (!sync2_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          led_q    <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign led_out     = led_q;
  assign active      = active_q;
  assign burst_count = burst_q;

endmodule

// File: tb/tb_alarm_led_sequencer.sv
// Bench for alarm_led_sequencer: two instances (limited and unlimited bursts) checked
// every cycle against a cycle-count reference model, plus directed timing checks.
module tb_alarm_led_sequencer;

  localparam int M_IDLE = 0, M_ON = 1, M_OFF = 2, M_PAUSE = 3, M_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       alarm_a = 1'b0, ack_a = 1'b0, alarm_b = 1'b0, ack_b = 1'b0;
  logic       led_a, active_a, led_b, active_b;
  logic [7:0] burst_a, burst_b;

  int checks = 0;
  int errors = 0;

  // Phase lengths in clock cycles, per instance
  int p_on[2]    = '{20, 1};
  int p_off[2]   = '{20, 1};
  int p_pul[2]   = '{3, 1};
  int p_pause[2] = '{50, 1};
  int p_max[2]   = '{2, 0};

  int m_mode[2], m_left[2], m_pul[2], m_bur[2];
  bit m_s1[2], m_s2[2];

  always #5 clk = ~clk;

  alarm_led_sequencer #(
    .CLK_FREQ_HZ(10000), .ON_MS(2), .OFF_MS(2), .PULSES(3), .PAUSE_MS(5), .MAX_BURSTS(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .alarm_in(alarm_a), .ack(ack_a),
    .led_out(led_a), .active(active_a), .burst_count(burst_a)
  );

  alarm_led_sequencer #(
    .CLK_FREQ_HZ(1000), .ON_MS(1), .OFF_MS(1), .PULSES(1), .PAUSE_MS(1), .MAX_BURSTS(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .alarm_in(alarm_b), .ack(ack_b),
    .led_out(led_b), .active(active_b), .burst_count(burst_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_left[i] = 0; m_pul[i] = 0; m_bur[i] = 0;
      m_s1[i] = 1'b0; m_s2[i] = 1'b0;
    end
  endtask

  // One clock of behaviour: priority is alarm withdrawn, then ack, then phase timeout
  task automatic model_step(input int i, input bit a, input bit k);
    bit s;
    s = m_s2[i];
    case (m_mode[i])
      M_IDLE: if (s) begin
        m_mode[i] = M_ON; m_left[i] = p_on[i]; m_pul[i] = 0; m_bur[i] = 0;
      end
      M_HOLD: if (!s) m_mode[i] = M_IDLE;
      default: begin
        if (!s) m_mode[i] = M_IDLE;
        else if (k) m_mode[i] = M_HOLD;
        else begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            if (m_mode[i] == M_ON) begin
              m_mode[i] = M_OFF; m_left[i] = p_off[i]; m_pul[i]++;
            end else if (m_mode[i] == M_OFF) begin
              if (m_pul[i] < p_pul[i]) begin
                m_mode[i] = M_ON; m_left[i] = p_on[i];
              end else begin
                m_bur[i] = (m_bur[i] < 255) ? m_bur[i] + 1 : 255;
                m_pul[i] = 0;
                if (p_max[i] != 0 && m_bur[i] == p_max[i]) m_mode[i] = M_HOLD;
                else begin
                  m_mode[i] = M_PAUSE; m_left[i] = p_pause[i];
                end
              end
            end else begin
              m_mode[i] = M_ON; m_left[i] = p_on[i];
            end
          end
        end
      end
    endcase
    m_s2[i] = m_s1[i];
    m_s1[i] = a;
  endtask

  task automatic tick();
    model_step(0, alarm_a, ack_a);
    model_step(1, alarm_b, ack_b);
    @(posedge clk);
    #1;
    check_eq("led_a", led_a, int'(m_mode[0] == M_ON));
    check_eq("active_a", active_a, int'(m_mode[0] inside {M_ON, M_OFF, M_PAUSE}));
    check_eq("burst_a", burst_a, m_bur[0]);
    check_eq("led_b", led_b, int'(m_mode[1] == M_ON));
    check_eq("active_b", active_b, int'(m_mode[1] inside {M_ON, M_OFF, M_PAUSE}));
    check_eq("burst_b", burst_b, m_bur[1]);
  endtask

  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_led_a", led_a, 0);
    check_eq("rst_active_a", active_a, 0);
    check_eq("rst_burst_a", burst_a, 0);
    check_eq("rst_active_b", active_b, 0);
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_q[$];
    logic prev;
    int n, len;

    // Burst timing from the first alarm edge
    @(posedge clk);
    apply_reset(2);
    alarm_a = 1'b1;
    prev = led_a;
    for (int e = 0; e < 180; e++) begin
      tick();
      if (led_a && !prev) rise_q.push_back(e);
      if (e == 121) check_eq("burst_before_pause", burst_a, 0);
      if (e == 122) check_eq("burst_in_pause", burst_a, 1);
      prev = led_a;
    end
    check_eq("rise_count", rise_q.size(), 4);
    if (rise_q.size() == 4) begin
      check_eq("rise0", rise_q[0], 2);
      check_eq("rise1", rise_q[1], 42);
      check_eq("rise2", rise_q[2], 82);
      check_eq("rise3", rise_q[3], 172);
    end

    // Burst limit reached -> HOLD, stays while alarm held, restart clears count
    repeat (170) tick();
    check_eq("limit_active", active_a, 0);
    check_eq("limit_led", led_a, 0);
    check_eq("limit_burst", burst_a, 2);
    repeat (60) tick();
    check_eq("hold_stays", active_a, 0);
    alarm_a = 1'b0;
    repeat (4) tick();
    alarm_a = 1'b1;
    repeat (3) tick();
    check_eq("restart_led", led_a, 1);
    check_eq("restart_burst", burst_a, 0);

    // Ack during the second ON of a burst
    for (n = 0; n < 100 && led_a; n++) tick();
    for (n = 0; n < 100 && !led_a; n++) tick();
    check_eq("second_on", led_a, 1);
    ack_a = 1'b1; tick(); ack_a = 1'b0;
    check_eq("ack_led", led_a, 0);
    check_eq("ack_active", active_a, 0);
    ack_a = 1'b1; tick(); ack_a = 1'b0;
    check_eq("ack_ignored", active_a, 0);
    alarm_a = 1'b0;
    repeat (4) tick();

    // Alarm withdrawn mid-PAUSE with ack arriving as the sync level falls
    alarm_a = 1'b1;
    for (n = 0; n < 300 && burst_a != 8'd1; n++) tick();
    repeat (10) tick();
    check_eq("in_pause", int'(active_a && !led_a), 1);
    alarm_a = 1'b0;
    tick(); tick();
    check_eq("pause_until_sync", active_a, 1);
    ack_a = 1'b1; tick(); ack_a = 1'b0;
    check_eq("drop_active", active_a, 0);
    check_eq("drop_burst_kept", burst_a, 1);
    repeat (3) tick();

    // Reset during OFF with alarm held
    alarm_a = 1'b1;
    for (n = 0; n < 20 && !led_a; n++) tick();
    for (n = 0; n < 30 && led_a; n++) tick();
    repeat (5) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_led", led_a, 0);
    check_eq("async_rst_active", active_a, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (n = 1; n <= 10; n++) begin
      tick();
      if (led_a) break;
    end
    check_eq("rst_release_latency", n, 3);
    len = 0;
    for (int g = 0; g < 40 && led_a; g++) begin
      len++;
      tick();
    end
    check_eq("rst_full_on", len, 20);
    alarm_a = 1'b0;
    repeat (4) tick();

    // Unlimited bursts saturate at 255
    alarm_b = 1'b1;
    repeat (1000) tick();
    check_eq("sat_burst", burst_b, 255);
    check_eq("sat_active", active_b, 1);
    alarm_b = 1'b0;
    repeat (4) tick();

    // Random alarm levels, acks and occasional resets
    for (int it = 0; it < 40; it++) begin
      int dur;
      if ($urandom_range(0, 9) == 0) apply_reset($urandom_range(1, 3));
      alarm_a = 1'($urandom_range(0, 1));
      alarm_b = 1'($urandom_range(0, 1));
      dur = $urandom_range(1, 200);
      for (int c = 0; c < dur; c++) begin
        ack_a = ($urandom_range(0, 31) == 0);
        ack_b = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 63) == 0) alarm_a = ~alarm_a;
        tick();
      end
      ack_a = 1'b0;
      ack_b = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_led_sequencer.md
ALARM_LED_SEQUENCER -- requirements
Module: alarm_led_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 50000000, clk frequency in Hz; integer multiple of 1000, at least 1000.
REQ-002 The block SHALL have parameter ON_MS, default 250, LED-on time per pulse in ms; at least 1.
REQ-003 The block SHALL have parameter OFF_MS, default 250, LED-off time after each pulse in ms; at least 1.
REQ-004 The block SHALL have parameter PULSES, default 3, pulses per burst; range 1..255.
REQ-005 The block SHALL have parameter PAUSE_MS, default 1000, dark gap between bursts in ms; at least 1.
REQ-006 The block SHALL have parameter MAX_BURSTS, default 60, bursts before automatic stop; range 0..255, 0 = unlimited.
REQ-007 The block SHALL have port clk, input, 1, system clock.
REQ-008 The block SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-009 The block SHALL have port alarm_in, input, 1, alarm-request level from the alarm LED PIO output register; may be asynchronous to clk.
REQ-010 The block SHALL have port ack, input, 1, synchronous single-cycle snooze/acknowledge pulse.
REQ-011 The block SHALL have port led_out, output, 1, LED drive, 1 = lit.
REQ-012 The block SHALL have port active, output, 1, high while the sequence runs (ON, OFF or PAUSE).
REQ-013 The block SHALL have port burst_count, output, 8, number of bursts completed since the sequence started.

Function
REQ-014 The block SHALL synchronise alarm_in through two clk flops (sync level = second flop); ack SHALL NOT be synchronised.
REQ-015 The block SHALL implement states IDLE, ON, OFF, PAUSE, HOLD; HOLD covers both ack and timeout stops.
REQ-016 The block SHALL use a ms prescaler of CLK_FREQ_HZ/1000 cycles and a ms phase counter, both cleared on every state entry, so each ON/OFF/PAUSE phase lasts exactly (phase_ms x CLK_FREQ_HZ/1000) cycles.
REQ-017 The block SHALL transition IDLE->ON when sync level = 1; on this entry pulse counter = 0 and burst_count = 0.
REQ-018 The block SHALL transition ON->OFF when ON_MS has elapsed; the pulse counter increments on this transition.
REQ-019 When OFF_MS elapses, the block SHALL go OFF->ON if pulse counter < PULSES; otherwise burst_count increments (saturating at 255), the pulse counter clears, and the next state is HOLD if MAX_BURSTS != 0 and the new burst_count = MAX_BURSTS, else PAUSE.
REQ-020 The block SHALL transition PAUSE->ON when PAUSE_MS has elapsed.
REQ-021 In ON, OFF or PAUSE, the block SHALL go to IDLE when sync level = 0 (alarm withdrawn), otherwise to HOLD when ack = 1.
REQ-022 The block SHALL transition HOLD->IDLE only when sync level = 0; ack in HOLD or IDLE SHALL be ignored.
REQ-023 The block SHALL apply priority per cycle of: reset > sync level 0 > ack > timer-driven transition.
REQ-024 The block SHALL drive led_out = 1 only in state ON, active = 1 only in ON, OFF and PAUSE, and burst_count = the register value in every state, holding its value in HOLD and IDLE until the next IDLE->ON.
REQ-025 The block SHALL decode all outputs from registered state only (glitch-free); latency SHALL be alarm_in rising (setup met before edge k) -> led_out = 1 after edge k+2.
REQ-026 The block SHALL size all counter widths from the parameters with no truncation, and SHALL NOT allow any counter to wrap.

Reset
REQ-027 On reset_n = 0, asynchronously: state = IDLE, sync flops = 0, all counters = 0, led_out = 0, active = 0, burst_count = 0.
REQ-028 Reset deassertion mid-alarm SHALL resume via IDLE->ON after two synchroniser cycles, with no partial-phase carry-over.

Verification (CLK_FREQ_HZ=10000 -> 10 cycles/ms; ON_MS=2, OFF_MS=2, PULSES=3, PAUSE_MS=5, MAX_BURSTS=2)
REQ-029 Rise alarm_in at edge 0 -> led_out = 1 from edge 2; ON 20 cycles, OFF 20 cycles; 3 pulses in 120 cycles; then PAUSE 50 cycles with burst_count = 1; next ON at cycle 172.
REQ-030 Hold alarm_in = 1 through 2 bursts -> after the second burst's final OFF, state = HOLD, burst_count = 2, active = 0, led_out = 0; continue to hold alarm_in = 1 -> stays HOLD; drop alarm_in -> IDLE; raise again -> restart with burst_count = 0.
REQ-031 Pulse ack during the second ON of a burst -> next cycle HOLD, led_out = 0; further ack ignored; alarm_in 0 -> IDLE.
REQ-032 Drop alarm_in mid-PAUSE while simultaneously pulsing ack -> IDLE (not HOLD) 2 cycles later; burst_count retained.
REQ-033 Assert reset_n = 0 for 3 cycles during OFF with alarm_in = 1 -> outputs 0 immediately; after release, led_out = 1 two cycles later with a full 20-cycle ON.
REQ-034 Set MAX_BURSTS=0, run 300 bursts -> never enters HOLD by timeout; burst_count saturates at 255.
